// File: rtl/regfile_bcd.sv
// Register file with two combinational read ports, one write port, optional write-to-read
// bypass, and a sequential double-dabble converter showing the last write. Macro: REGFILE_ZERO_REG_EN.
module regfile_bcd #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  parameter  int DIGITS = 3,
  parameter  int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     ReadReg1,
  input  logic [ADDR_W-1:0]     ReadReg2,
  input  logic [ADDR_W-1:0]     WriteReg,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic                  RegWrite,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  BCDValid,
  output logic                  BCDBusy
);

  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      regs_q [DEPTH];
  logic [SR_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pend_q, pend_d;
  logic [WIDTH-1:0]      pval_q, pval_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  wr_acc;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_acc = RegWrite && !reset && (WriteReg != '0);
`else
  assign wr_acc = RegWrite && !reset;
`endif

  // NOTE: the array is reset explicitly because the register file must read 0 after reset;
  // a memory without that requirement would be left unreset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_acc) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] r;
    r = regs_q[addr];
    if (BYPASS != 0 && RegWrite && addr == WriteReg) r = WriteData;
`ifdef REGFILE_ZERO_REG_EN
    if (addr == '0) r = '0;
`endif
    return r;
  endfunction

  assign ReadData1 = read_port(ReadReg1);
  assign ReadData2 = read_port(ReadReg2);

  // One double-dabble step: correct every BCD digit >= 5, then shift the whole register left.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[WIDTH+4*d +: 4] >= 4'd5) t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (wr_acc || pend_q) state_d = S_SHIFT;
      S_SHIFT: if (count_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          shift_d = {{(4*DIGITS){1'b0}}, WriteData};
          count_d = CNT_W'(WIDTH);
          pend_d  = 1'b0;
        end else if (pend_q) begin
          shift_d = {{(4*DIGITS){1'b0}}, pval_q};
          count_d = CNT_W'(WIDTH);
          pend_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        shift_d = dabble(shift_q);
        count_d = count_q - CNT_W'(1);
      end
      S_DONE: begin
        bcd_d   = shift_q[SR_W-1 -: 4*DIGITS];
        valid_d = ~(pend_q | wr_acc);
      end
      default: ;
    endcase
    if (wr_acc && state_q != S_IDLE) begin
      pend_d = 1'b1;
      pval_d = WriteData;
    end
    if (wr_acc) valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    BCD      = bcd_q;
    BCDValid = valid_q;
    BCDBusy  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_regfile_bcd.sv
// Self-checking bench for regfile_bcd: directed scenarios plus random traffic against a
// transaction-level model. Instance u_a uses BYPASS=1, u_b uses BYPASS=0, same stimulus.
module tb_regfile_bcd;

  localparam int WIDTH = 8;

  logic       clk;
  logic       reset;
  logic [1:0] ReadReg1, ReadReg2, WriteReg;
  logic [7:0] WriteData;
  logic       RegWrite;
  logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [11:0] bcd_a, bcd_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  regfile_bcd #(.WIDTH(8), .DEPTH(4), .DIGITS(3), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_a), .ReadData2(rd2_a), .BCD(bcd_a), .BCDValid(valid_a), .BCDBusy(busy_a));

  regfile_bcd #(.WIDTH(8), .DEPTH(4), .DIGITS(3), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .BCD(bcd_b), .BCDValid(valid_b), .BCDBusy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents plus the converter seen as timed transactions.
  int   m_regs [4];
  logic [11:0] m_bcd;
  bit   m_valid, m_busy, m_pend;
  int   m_conv, m_pval, m_done_at, cyc;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit write_counts();
`ifdef REGFILE_ZERO_REG_EN
    return RegWrite && WriteReg != 2'd0;
`else
    return RegWrite;
`endif
  endfunction

  function automatic int exp_read(input logic [1:0] addr, input bit bypass);
`ifdef REGFILE_ZERO_REG_EN
    if (addr == 2'd0) return 0;
`endif
    if (bypass && RegWrite && addr == WriteReg) return int'(WriteData);
    return m_regs[addr];
  endfunction

  task automatic model_edge();
    bit wr;
    wr = write_counts();
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_bcd = '0; m_valid = 0; m_busy = 0; m_pend = 0;
    end else begin
      if (!m_busy) begin
        if (wr) begin
          m_busy = 1; m_conv = int'(WriteData); m_done_at = cyc + WIDTH + 1;
        end else if (m_pend) begin
          m_busy = 1; m_conv = m_pval; m_done_at = cyc + WIDTH + 1; m_pend = 0;
        end
      end else begin
        if (cyc == m_done_at) begin
          m_bcd = to_bcd(m_conv);
          m_valid = !(m_pend || wr);
          m_busy = 0;
        end
        if (wr) begin
          m_pend = 1; m_pval = int'(WriteData);
        end
      end
      if (wr) begin
        m_regs[WriteReg] = int'(WriteData);
        m_valid = 0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; RegWrite = 0; WriteReg = 0; WriteData = 0; ReadReg1 = 0; ReadReg2 = 0;
    tick(); tick();
    reset = 0;
    for (int a = 0; a < 4; a++) begin
      ReadReg1 = 2'(a); ReadReg2 = 2'(3 - a);
      #1;
      n_vec++;
      if (rd1_a !== 8'd0 || rd2_a !== 8'd0 || rd1_b !== 8'd0 || rd2_b !== 8'd0) begin
        n_err++;
        $display("FAIL reset_read addr %0d: got %0d/%0d/%0d/%0d expected 0", a, rd1_a, rd2_a, rd1_b, rd2_b);
      end
    end
    n_vec++;
    if (bcd_a !== 12'h000 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_bcd: got bcd=%h valid=%b busy=%b expected 000/0/0", bcd_a, valid_a, busy_a);
    end
  endtask

  task automatic test_convert();
    RegWrite = 1; WriteReg = 2; WriteData = 8'd237; ReadReg1 = 2; ReadReg2 = 2;
    #1;
    n_vec++;
    if (rd1_a !== 8'd237 || rd1_b !== 8'd0) begin
      n_err++;
      $display("FAIL bypass_237: got byp=%0d nobyp=%0d expected 237/0", rd1_a, rd1_b);
    end
    tick();
    RegWrite = 0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (k > 0) tick();
      n_vec++;
      if (busy_a !== 1'b1) begin
        n_err++;
        $display("FAIL busy_237 edge N+%0d: got %b expected 1", k, busy_a);
      end
    end
    tick();
    n_vec++;
    if (bcd_a !== 12'h237 || valid_a !== 1'b1 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL bcd_237: got bcd=%h valid=%b busy=%b expected 237/1/0", bcd_a, valid_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    RegWrite = 1; WriteReg = 1; WriteData = 8'd15;  tick();
    RegWrite = 0;                                    tick();
    RegWrite = 1; WriteReg = 3; WriteData = 8'd99;  tick();
    RegWrite = 0;                                    tick();
    RegWrite = 1; WriteReg = 3; WriteData = 8'd200; tick();
    RegWrite = 0;
    repeat (5) tick();
    n_vec++;
    if (bcd_a !== 12'h015 || valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got bcd=%h valid=%b expected 015/0", bcd_a, valid_a);
    end
    repeat (10) tick();
    n_vec++;
    if (bcd_a !== 12'h200 || valid_a !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_final: got bcd=%h valid=%b expected 200/1", bcd_a, valid_a);
    end
    ReadReg1 = 3; ReadReg2 = 1;
    #1;
    n_vec++;
    if (rd1_a !== 8'd200 || rd2_a !== 8'd15) begin
      n_err++;
      $display("FAIL b2b_regs: got r3=%0d r1=%0d expected 200/15", rd1_a, rd2_a);
    end
  endtask

  task automatic test_reg0();
    RegWrite = 1; WriteReg = 0; WriteData = 8'd255; ReadReg1 = 0;
    tick();
    RegWrite = 0;
`ifdef REGFILE_ZERO_REG_EN
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (busy_a !== 1'b0 || valid_a !== 1'b1 || rd1_a !== 8'd0) begin
        n_err++;
        $display("FAIL reg0_zero cyc %0d: got busy=%b valid=%b rd=%0d expected 0/1/0", k, busy_a, valid_a, rd1_a);
      end
      tick();
    end
`else
    repeat (9) tick();
    n_vec++;
    if (bcd_a !== 12'h255 || valid_a !== 1'b1 || rd1_a !== 8'd255) begin
      n_err++;
      $display("FAIL reg0_255: got bcd=%h valid=%b rd=%0d expected 255/1/255", bcd_a, valid_a, rd1_a);
    end
`endif
  endtask

  task automatic test_reset_abort();
    RegWrite = 1; WriteReg = 1; WriteData = 8'd128; tick();
    RegWrite = 0;
    repeat (4) tick();
    reset = 1; RegWrite = 1; WriteReg = 2; WriteData = 8'd77;
    tick();
    reset = 0; RegWrite = 0;
    n_vec++;
    if (busy_a !== 1'b0 || bcd_a !== 12'h000 || valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b bcd=%h valid=%b expected 0/000/0", busy_a, bcd_a, valid_a);
    end
    for (int a = 0; a < 4; a++) begin
      ReadReg1 = 2'(a); ReadReg2 = 2'(a);
      #1;
      n_vec++;
      if (rd1_a !== 8'd0 || rd2_b !== 8'd0) begin
        n_err++;
        $display("FAIL abort_regs addr %0d: got %0d/%0d expected 0", a, rd1_a, rd2_b);
      end
    end
    tick();
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_nostart: got busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_no_bypass();
    ReadReg2 = 1; RegWrite = 1; WriteReg = 1; WriteData = 8'd42;
    #1;
    n_vec++;
    if (rd2_b !== 8'd0 || rd2_a !== 8'd42) begin
      n_err++;
      $display("FAIL nobyp_during: got nobyp=%0d byp=%0d expected 0/42", rd2_b, rd2_a);
    end
    tick();
    RegWrite = 0;
    #1;
    n_vec++;
    if (rd2_b !== 8'd42) begin
      n_err++;
      $display("FAIL nobyp_after: got %0d expected 42", rd2_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RegWrite  = ($urandom_range(0, 3) == 0);
      WriteReg  = 2'($urandom_range(0, 3));
      WriteData = 8'($urandom);
      ReadReg1  = 2'($urandom_range(0, 3));
      ReadReg2  = (i % 3 == 0) ? WriteReg : 2'($urandom_range(0, 3));
      #1;
      n_vec++;
      if (int'(rd1_a) != exp_read(ReadReg1, 1) || int'(rd2_a) != exp_read(ReadReg2, 1) ||
          int'(rd1_b) != exp_read(ReadReg1, 0) || int'(rd2_b) != exp_read(ReadReg2, 0)) begin
        n_err++;
        $display("FAIL rand_read %0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d", i,
                 rd1_a, rd2_a, rd1_b, rd2_b, exp_read(ReadReg1, 1), exp_read(ReadReg2, 1),
                 exp_read(ReadReg1, 0), exp_read(ReadReg2, 0));
      end
      tick();
      n_vec++;
      if (bcd_a !== m_bcd || valid_a !== m_valid || busy_a !== m_busy || bcd_b !== m_bcd) begin
        n_err++;
        $display("FAIL rand_conv %0d: got bcd=%h valid=%b busy=%b expected %h/%b/%b", i,
                 bcd_a, valid_a, busy_a, m_bcd, m_valid, m_busy);
      end
    end
    RegWrite = 0;
    repeat (2 * (WIDTH + 2) + 2) tick();
    n_vec++;
    if (bcd_a !== m_bcd || valid_a !== m_valid || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain: got bcd=%h valid=%b busy=%b expected %h/%b/0", bcd_a, valid_a, busy_a, m_bcd, m_valid);
    end
  endtask

  initial begin
    cyc = 0; m_pend = 0; m_busy = 0; m_valid = 0; m_bcd = '0; m_conv = 0; m_pval = 0; m_done_at = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
    test_reset();
    test_convert();
    test_back_to_back();
    test_reg0();
    test_reset_abort();
    test_no_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
